launch_scheduler: RTL and testbench
===================================

# launch_scheduler

Queues and sequences missile launch commands between the PS/2 command interpreter and the launch/physics engine. Each `queue` pulse captures the current `velocity`/`angle` pair into a small FIFO. A `fire` pulse drains the FIFO one shot at a time over a valid/ready handshake, with a fixed cooldown between shots, so the engine only ever sees one launch in flight.

## Interface
- `DEPTH`, default 4: FIFO entries; legal range 1..8.
- `COOLDOWN_CYCLES`, default 1000: cycles spent in COOLDOWN after each accepted launch; legal range ≥1.

- `clock` in 1: system clock; all logic on posedge.
- `reset` in 1: synchronous, active-high reset.
- `velocity` in 32: current velocity from the interpreter.
- `angle` in 32: current angle from the interpreter.
- `queue` in 1: one-cycle pulse; push {velocity, angle} into the FIFO.
- `fire` in 1: one-cycle pulse; start draining the FIFO.
- `launch_ready` in 1: engine accepts the presented launch.
- `launch_valid` out 1: a launch is presented.
- `launch_velocity` out 32: velocity of the presented launch.
- `launch_angle` out 32: angle of the presented launch.
- `queue_count` out 4: number of FIFO entries.
- `busy` out 1: high in ISSUE or COOLDOWN.
- `overflow` out 1: one-cycle pulse when a push is rejected.

## Operation
- Outputs at reset: `launch_valid`=0, `launch_velocity`=0, `launch_angle`=0, `queue_count`=0, `busy`=0, `overflow`=0.
- State at reset: state=IDLE, FIFO read/write pointers cleared, cooldown counter=0.
- FIFO is a circular buffer of DEPTH×64 bits; pointers wrap modulo DEPTH.
- Push:
  - On `queue` with count<DEPTH, write the pair at the write pointer, then write pointer +1 and count +1.
  - On `queue` with count==DEPTH, drop the pair and pulse `overflow` for one cycle. This applies even if a pop happens in the same cycle.
- States:
  - IDLE:
    - If `fire` and (count≠0 or `queue` in the same cycle), go to ISSUE.
    - Otherwise, handle `fire` as described under Configuration.
  - ISSUE:
    - `launch_valid`=1; `launch_velocity`/`launch_angle` = FIFO head, registered.
    - Data is held stable while `launch_ready`=0.
    - When `launch_valid`&`launch_ready` at a posedge, pop the head (count −1), load the cooldown counter with COOLDOWN_CYCLES, and go to COOLDOWN.
  - COOLDOWN:
    - `launch_valid`=0; the counter decrements each cycle.
    - At 1: if count≠0 go to ISSUE, else go to IDLE.
- `fire` in ISSUE or COOLDOWN is ignored, because a drain is already running.
- `queue` during a drain is accepted; the new entry is launched in the same burst.
- Push and pop in the same cycle with count<DEPTH leave count unchanged.
- `launch_velocity`/`launch_angle` hold their last issued value when `launch_valid`=0.
- `busy` = state≠IDLE.
- Reset mid-operation: all queued entries are discarded, and `launch_valid` is 0 after the reset edge even if a launch was being presented.

## Timing
- Push → `queue_count` updates at the next posedge; latency 1.
- `fire` in IDLE with count≠0 → `launch_valid` high from the next posedge; latency 1.
- Accept edge t → `launch_valid` low from t; the next `launch_valid` rises at edge t+COOLDOWN_CYCLES, so the minimum gap is COOLDOWN_CYCLES cycles low.
- `launch_valid` never drops without acceptance, except on reset.
- `overflow` is high for exactly the one cycle after the rejected push.

## Configuration
- Macro: `LAUNCH_DIRECT_FIRE_EN`.
- Defined:
  - `fire` in IDLE with count==0 and no same-cycle `queue` goes to ISSUE. It presents the `velocity`/`angle` sampled on the `fire` cycle, without touching the FIFO.
  - After acceptance, it follows the normal COOLDOWN → IDLE path.
- Undefined: that `fire` is ignored; the state stays IDLE and no outputs change.

## Test plan
- Reset then 3 queued shots: queue (v=10,a=45), (20,30), (30,60); fire; `launch_ready` tied 1; COOLDOWN_CYCLES=4.
  - Expect three launches in order.
  - `launch_valid` rises 1 cycle after fire, with 4-cycle gaps between launches.
  - `queue_count` goes 3→0; `busy` falls after the last cooldown.
- Backpressure: queue one entry, fire, hold `launch_ready`=0 for 10 cycles.
  - Expect `launch_valid` and data stable for all 10 cycles.
  - Single accept when ready goes high; count goes 1→0.
- Overflow: DEPTH=4, send 5 queue pulses.
  - Expect count=4 and `overflow` pulsed once, on the cycle after the 5th queue.
  - Subsequent drain yields only the first 4 pairs.
- Queue during drain: queue 1 entry and fire; queue another during COOLDOWN.
  - Expect both launched with no second fire needed.
- Empty fire: fire with count=0, velocity=7, angle=9.
  - With `LAUNCH_DIRECT_FIRE_EN`: one launch (7,9) is presented 1 cycle later.
  - Without it: `launch_valid` stays 0 and `busy` stays 0.
- Reset mid-drain: queue 3 entries, fire, assert `reset` while `launch_valid`=1.
  - Expect `launch_valid`=0, count=0, state IDLE after the edge; a later fire does nothing (macro undefined).

Source files
------------

// File: rtl/launch_scheduler.sv
// launch_scheduler
//
// Queues launch commands from the command interpreter and releases them to
// the launch/physics engine one at a time.
//
// Each `queue` pulse stores the current velocity/angle pair in a small
// circular FIFO. A `fire` pulse starts a drain. During a drain the head entry
// is offered on a valid/ready handshake. Every accepted launch is followed by
// a fixed cooldown, so the engine never sees more than one launch in flight.
//
// Parameters
//   DEPTH            FIFO entries, 1..8
//   COOLDOWN_CYCLES  cycles spent cooling down after each accepted launch, >=1
//
// Ports
//   clock            system clock, rising edge
//   reset            synchronous, active-high
//   velocity, angle  current command operands (32 bit each)
//   queue            pulse: push {velocity, angle}
//   fire             pulse: start draining the FIFO
//   launch_ready     engine accepts the presented launch
//   launch_valid     a launch is presented
//   launch_velocity  velocity of the presented (or last presented) launch
//   launch_angle     angle of the presented (or last presented) launch
//   queue_count      number of FIFO entries
//   busy             a drain is in progress (ISSUE or COOLDOWN)
//   overflow         one-cycle pulse after a push was dropped on a full FIFO
//
// Optional feature, macro LAUNCH_DIRECT_FIRE_EN:
//   When the macro is defined, a `fire` with an empty FIFO and no
//   same-cycle `queue` launches the live velocity/angle directly, bypassing
//   the FIFO. When it is undefined, such a `fire` is ignored.

module launch_scheduler #(
  parameter int DEPTH           = 4,
  parameter int COOLDOWN_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] velocity,
  input  logic [31:0] angle,
  input  logic        queue,
  input  logic        fire,
  input  logic        launch_ready,
  output logic        launch_valid,
  output logic [31:0] launch_velocity,
  output logic [31:0] launch_angle,
  output logic [3:0]  queue_count,
  output logic        busy,
  output logic        overflow
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  DEPTH_L = 4'(DEPTH);
  localparam logic [31:0] COOL_L  = 32'(COOLDOWN_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t             state;
  logic [63:0]        mem [DEPTH];
  logic [IDX_W-1:0]   wr_ptr;
  logic [IDX_W-1:0]   rd_ptr;
  logic [3:0]         count;
  logic [31:0]        cool_cnt;
  // Set while the presented launch came straight from the inputs rather than
  // from the FIFO, so its acceptance must not pop an entry.
  logic               direct;

  logic               push_ok;
  logic               accept;
  logic               pop;
  logic [63:0]        head;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] ptr);
    if (ptr == IDX_W'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

  always_comb begin
    push_ok = queue && (count < DEPTH_L);
    accept  = (state == ISSUE) && launch_valid && launch_ready;
    pop     = accept && !direct;
    head    = mem[rd_ptr];
  end

  assign queue_count = count;

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      cool_cnt        <= '0;
      direct          <= 1'b0;
      launch_valid    <= 1'b0;
      launch_velocity <= '0;
      launch_angle    <= '0;
      busy            <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      // A full FIFO rejects the push even if the head is popped this cycle.
      overflow <= queue && (count == DEPTH_L);

      if (push_ok) begin
        mem[wr_ptr] <= {velocity, angle};
        wr_ptr      <= wrap_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      count <= count + 4'(push_ok) - 4'(pop);

      case (state)
        IDLE: begin
          if (fire && ((count != 4'd0) || queue)) begin
            state        <= ISSUE;
            busy         <= 1'b1;
            launch_valid <= 1'b1;
            // With an empty FIFO the same-cycle push becomes the head.
            if (count != 4'd0) begin
              {launch_velocity, launch_angle} <= head;
            end else begin
              {launch_velocity, launch_angle} <= {velocity, angle};
            end
          end
`ifdef LAUNCH_DIRECT_FIRE_EN
          else if (fire) begin
            state           <= ISSUE;
            busy            <= 1'b1;
            launch_valid    <= 1'b1;
            direct          <= 1'b1;
            launch_velocity <= velocity;
            launch_angle    <= angle;
          end
`endif
        end

        ISSUE: begin
          if (launch_ready) begin
            state        <= COOLDOWN;
            launch_valid <= 1'b0;
            direct       <= 1'b0;
            cool_cnt     <= COOL_L;
          end
        end

        COOLDOWN: begin
          // Leaving on the count of 1 puts the next rising edge of
          // launch_valid exactly COOLDOWN_CYCLES edges after the accept.
          if (cool_cnt <= 32'd1) begin
            cool_cnt <= '0;
            if (count != 4'd0) begin
              state                           <= ISSUE;
              launch_valid                    <= 1'b1;
              {launch_velocity, launch_angle} <= head;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cool_cnt <= cool_cnt - 32'd1;
          end
        end

        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          launch_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_launch_scheduler.sv
// Testbench for launch_scheduler: directed scenarios followed by random
// traffic. Every cycle the outputs are compared against a queue-based model
// that tracks the drain as "presenting" / "cooling until cycle N".

module tb_launch_scheduler;

  localparam int DEPTH = 4;
  localparam int CD    = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] velocity;
  logic [31:0] angle;
  logic        queue;
  logic        fire;
  logic        launch_ready;
  logic        launch_valid;
  logic [31:0] launch_velocity;
  logic [31:0] launch_angle;
  logic [3:0]  queue_count;
  logic        busy;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  launch_scheduler #(
    .DEPTH          (DEPTH),
    .COOLDOWN_CYCLES(CD)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .velocity       (velocity),
    .angle          (angle),
    .queue          (queue),
    .fire           (fire),
    .launch_ready   (launch_ready),
    .launch_valid   (launch_valid),
    .launch_velocity(launch_velocity),
    .launch_angle   (launch_angle),
    .queue_count    (queue_count),
    .busy           (busy),
    .overflow       (overflow)
  );

  // Reference model state
  logic [63:0] mq[$];
  bit          m_drain;
  bit          m_pres;
  bit          m_direct;
  bit          m_ovf;
  logic [63:0] m_data;
  int          cyc;
  int          resume_at;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int old_size;
    old_size = mq.size();
    cyc++;
    if (reset) begin
      mq.delete();
      m_drain  = 0;
      m_pres   = 0;
      m_direct = 0;
      m_ovf    = 0;
      m_data   = '0;
      return;
    end
    m_ovf = queue && (old_size == DEPTH);
    if (queue && (old_size < DEPTH)) mq.push_back({velocity, angle});
    if (!m_drain) begin
      if (fire && (old_size != 0 || queue)) begin
        m_drain = 1;
        m_pres  = 1;
        m_data  = mq[0];
      end
`ifdef LAUNCH_DIRECT_FIRE_EN
      else if (fire) begin
        m_drain  = 1;
        m_pres   = 1;
        m_direct = 1;
        m_data   = {velocity, angle};
      end
`endif
    end else if (m_pres) begin
      if (launch_ready) begin
        m_pres = 0;
        if (!m_direct) void'(mq.pop_front());
        m_direct  = 0;
        resume_at = cyc + CD;
      end
    end else if (cyc == resume_at) begin
      if (old_size != 0) begin
        m_pres = 1;
        m_data = mq[0];
      end else begin
        m_drain = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("launch_valid", 64'(launch_valid), 64'(m_pres));
    check("launch_velocity", 64'(launch_velocity), 64'(m_data[63:32]));
    check("launch_angle", 64'(launch_angle), 64'(m_data[31:0]));
    check("queue_count", 64'(queue_count), 64'(mq.size()));
    check("busy", 64'(busy), 64'(m_drain));
    check("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  task automatic step(input bit q, input bit f, input bit r,
                      input logic [31:0] v, input logic [31:0] a, input bit rst);
    reset        = rst;
    queue        = q;
    fire         = f;
    launch_ready = r;
    velocity     = v;
    angle        = a;
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(0, 0, r, 32'd0, 32'd0, 0);
  endtask

  initial begin
    cyc      = 0;
    m_data   = '0;
    m_drain  = 0;
    m_pres   = 0;
    m_direct = 0;
    m_ovf    = 0;
    resume_at = 0;
    reset = 1; queue = 0; fire = 0; launch_ready = 0; velocity = '0; angle = '0;

    // Reset state
    step(0, 0, 0, 32'd0, 32'd0, 1);
    step(0, 0, 0, 32'd0, 32'd0, 1);
    check("rst_valid", 64'(launch_valid), 64'd0);
    check("rst_count", 64'(queue_count), 64'd0);

    // Three queued shots, ready tied high
    step(1, 0, 1, 32'd10, 32'd45, 0);
    step(1, 0, 1, 32'd20, 32'd30, 0);
    step(1, 0, 1, 32'd30, 32'd60, 0);
    check("s1_count3", 64'(queue_count), 64'd3);
    step(0, 1, 1, 32'd0, 32'd0, 0);
    check("s1_first_valid", 64'(launch_valid), 64'd1);
    check("s1_first_vel", 64'(launch_velocity), 64'd10);
    check("s1_first_ang", 64'(launch_angle), 64'd45);
    idle(3 * (CD + 1) + 3, 1);
    check("s1_done_busy", 64'(busy), 64'd0);
    check("s1_done_count", 64'(queue_count), 64'd0);

    // Backpressure
    step(1, 0, 0, 32'd5, 32'd6, 0);
    step(0, 1, 0, 32'd0, 32'd0, 0);
    idle(10, 0);
    check("bp_hold_valid", 64'(launch_valid), 64'd1);
    check("bp_hold_vel", 64'(launch_velocity), 64'd5);
    step(0, 0, 1, 32'd0, 32'd0, 0);
    check("bp_count0", 64'(queue_count), 64'd0);
    idle(CD + 4, 1);

    // Overflow: five pushes into four entries
    for (int i = 0; i < 5; i++) step(1, 0, 0, 32'(100 + i), 32'(200 + i), 0);
    check("ovf_pulse", 64'(overflow), 64'd1);
    check("ovf_count", 64'(queue_count), 64'd4);
    step(0, 1, 1, 32'd0, 32'd0, 0);
    check("ovf_pulse_gone", 64'(overflow), 64'd0);
    idle(4 * (CD + 1) + 4, 1);

    // Queue during drain
    step(1, 1, 1, 32'd1, 32'd2, 0);
    step(0, 0, 1, 32'd0, 32'd0, 0);
    step(1, 0, 1, 32'd3, 32'd4, 0);
    idle(2 * (CD + 1) + 4, 1);
    check("qd_busy", 64'(busy), 64'd0);

    // Empty fire
    step(0, 1, 0, 32'd7, 32'd9, 0);
`ifdef LAUNCH_DIRECT_FIRE_EN
    check("ef_valid", 64'(launch_valid), 64'd1);
    check("ef_vel", 64'(launch_velocity), 64'd7);
    check("ef_ang", 64'(launch_angle), 64'd9);
`else
    check("ef_valid", 64'(launch_valid), 64'd0);
    check("ef_busy", 64'(busy), 64'd0);
`endif
    idle(CD + 4, 1);

    // Reset mid-drain
    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'(50 + i), 32'(60 + i), 0);
    step(0, 1, 0, 32'd0, 32'd0, 0);
    step(0, 0, 0, 32'd0, 32'd0, 0);
    step(0, 0, 0, 32'd0, 32'd0, 1);
    check("rmd_valid", 64'(launch_valid), 64'd0);
    check("rmd_count", 64'(queue_count), 64'd0);
    check("rmd_busy", 64'(busy), 64'd0);
    step(0, 1, 1, 32'd11, 32'd12, 0);
`ifndef LAUNCH_DIRECT_FIRE_EN
    check("rmd_fire_ignored", 64'(launch_valid), 64'd0);
`endif
    idle(CD + 4, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(3) == 0), ($urandom_range(7) == 0), ($urandom_range(1) == 1),
           $urandom, $urandom, ($urandom_range(199) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
